sample_queue: RTL and testbench

SAMPLE_QUEUE -- requirements
Module: sample_queue

---
 rtl/sample_queue.sv | 104 ++++++++++
 tb/tb_sample_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sample_queue.sv
// Dual-channel sample history buffer. Each strobe that leaves the buffer full
// replays the FILL most recent left/right samples, oldest first, to the FIR filters.
module sample_queue #(
  parameter int DEPTH = 1024,
  parameter int FILL  = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        sequencing
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FILL + 1);
  localparam logic [CW-1:0] FILL_C  = CW'(FILL);
  localparam logic [CW-1:0] FILL_M1 = CW'(FILL - 1);

  // state | meaning
  // IDLE  | collecting samples, outputs held at zero
  // READ  | replaying FILL samples from rd_ptr, one per cycle
  typedef enum logic {IDLE, READ} state_t;

  logic [15:0]   mem_l [DEPTH];
  logic [15:0]   mem_r [DEPTH];
  logic [15:0]   rd_l;
  logic [15:0]   rd_r;

  logic [AW-1:0] new_ptr;
  logic [AW-1:0] old_ptr;
  logic [AW-1:0] old_nxt;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_left;
  logic          full;
  logic          start;
  state_t        state;

  assign full    = (cnt == FILL_C);
  assign old_nxt = (wrt_smpl && full) ? old_ptr + AW'(1) : old_ptr;
  assign start   = wrt_smpl && (full || (cnt == FILL_M1));

  always_ff @(posedge clk) begin
    if (wrt_smpl) begin
      mem_l[new_ptr] <= lft_smpl;
      mem_r[new_ptr] <= rght_smpl;
    end
  end

  // Plain synchronous read port (no reset) so the arrays map onto block RAM.
  always_ff @(posedge clk) begin
    rd_l <= mem_l[rd_ptr];
    rd_r <= mem_r[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      old_ptr <= '0;
      cnt     <= '0;
    end else if (wrt_smpl) begin
      new_ptr <= new_ptr + AW'(1);
      old_ptr <= old_nxt;
      if (!full) cnt <= cnt + CW'(1);
    end
  end

  // Writes arriving in READ only move the pointers; the replay in flight is untouched
  // because the write pointer stays at least two entries clear of the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      rd_left    <= '0;
      sequencing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sequencing <= 1'b0;
          if (start) begin
            state   <= READ;
            rd_ptr  <= old_nxt;
            rd_left <= FILL_C;
          end
        end
        READ: begin
          sequencing <= 1'b1;
          rd_ptr     <= rd_ptr + AW'(1);
          rd_left    <= rd_left - CW'(1);
          if (rd_left == CW'(1)) state <= IDLE;
        end
      endcase
    end
  end

  // Both operands are flops; gating by sequencing also zeroes the outputs the
  // instant reset is asserted.
  assign lft_out  = sequencing ? rd_l : 16'h0000;
  assign rght_out = sequencing ? rd_r : 16'h0000;

endmodule

// File: tb/tb_sample_queue.sv
// Bench for sample_queue: hand-derived vector table, corner sequences and random
// stimulus on a DEPTH=8/FILL=5 instance, plus a long-window run on the default instance.
module tb_sample_queue;

  localparam int SD = 8;
  localparam int SF = 5;
  localparam int BF = 1021;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_s = 1'b0;
  logic [15:0] l_s = '0, r_s = '0;
  logic [15:0] lo_s, ro_s;
  logic        seq_s;
  logic        wr_b = 1'b0;
  logic [15:0] l_b = '0, r_b = '0;
  logic [15:0] lo_b, ro_b;
  logic        seq_b;

  always #5 clk = ~clk;

  sample_queue #(.DEPTH(SD), .FILL(SF)) u_s (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wr_s), .lft_smpl(l_s), .rght_smpl(r_s),
    .lft_out(lo_s), .rght_out(ro_s), .sequencing(seq_s));

  sample_queue u_b (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wr_b), .lft_smpl(l_b), .rght_smpl(r_b),
    .lft_out(lo_b), .rght_out(ro_b), .sequencing(seq_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: sample history plus a queue of outputs still to be replayed.
  logic [15:0] hl[$], hr[$], ql[$], qr[$], cap_l[$];

  task automatic model_reset();
    hl.delete(); hr.delete(); ql.delete(); qr.delete();
  endtask

  task automatic model_edge(input logic wr, input logic [15:0] l, input logic [15:0] r,
                            output logic es, output logic [15:0] el, output logic [15:0] er);
    bit in_read;
    in_read = (ql.size() != 0);
    es = 1'b0; el = '0; er = '0;
    if (in_read) begin
      es = 1'b1; el = ql.pop_front(); er = qr.pop_front();
    end
    if (wr) begin
      hl.push_back(l); hr.push_back(r);
      if (hl.size() > SF) begin
        void'(hl.pop_front()); void'(hr.pop_front());
      end
      if (!in_read && hl.size() == SF)
        for (int i = 0; i < SF; i++) begin
          ql.push_back(hl[i]); qr.push_back(hr[i]);
        end
    end
  endtask

  task automatic step(input logic wr, input logic [15:0] l, input logic [15:0] r);
    logic es;
    logic [15:0] el, er;
    @(negedge clk);
    wr_s = wr; l_s = l; r_s = r;
    @(posedge clk);
    model_edge(wr, l, r, es, el, er);
    #1;
    check("model", {seq_s, lo_s, ro_s}, {es, el, er});
    if (seq_s) cap_l.push_back(lo_s);
    wr_s = 1'b0;
  endtask

  task automatic check_cap(input string name, input int n, input int first);
    check({name, "_len"}, 33'(cap_l.size()), 33'(n));
    for (int i = 0; i < n && i < cap_l.size(); i++)
      check({name, "_data"}, 33'(cap_l[i]), 33'(first + i));
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] l;
    logic        es;
    logic [15:0] el;
  } vec_t;

  vec_t tbl[11];
  logic [15:0] bh_l[2048], bh_r[2048];
  int n_b;

  initial begin
    for (int i = 0; i < 11; i++) begin
      tbl[i].wr = (i < 5);
      tbl[i].l  = (i < 5) ? 16'(i + 1) : 16'h0;
      tbl[i].es = (i >= 5 && i <= 9);
      tbl[i].el = tbl[i].es ? 16'(i - 4) : 16'h0;
    end

    #12;
    check("reset_s", {seq_s, lo_s, ro_s}, 33'h0);
    check("reset_b", {seq_b, lo_b, ro_b}, 33'h0);
    @(negedge clk); rst_n = 1'b1;

    // Fill with 1..5 back-to-back, replay must follow one cycle after the 5th strobe.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wr, tbl[i].l, 16'(-tbl[i].l));
      check("vec", {seq_s, lo_s, ro_s}, {tbl[i].es, tbl[i].el, 16'(-tbl[i].el)});
    end

    // Samples 6..12 cross the pointer wrap.
    for (int v = 6; v <= 12; v++) begin
      cap_l.delete();
      step(1'b1, 16'(v), 16'(-v));
      repeat (6) step(1'b0, '0, '0);
    end
    check_cap("wrap12", 5, 8);

    // Strobe two cycles into a replay: no restart, no extension, no second pulse.
    cap_l.delete();
    step(1'b1, 16'd13, 16'(-13));
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    step(1'b1, 16'd14, 16'(-14));
    repeat (8) step(1'b0, '0, '0);
    check_cap("midread", 5, 9);
    cap_l.delete();
    step(1'b1, 16'd15, 16'(-15));
    repeat (6) step(1'b0, '0, '0);
    check_cap("after_mid", 5, 11);

    // Reset in the third replay cycle, then the queue must refill.
    step(1'b1, 16'd16, 16'(-16));
    repeat (3) step(1'b0, '0, '0);
    check("pre_rst_seq", 33'(seq_s), 33'h1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {seq_s, lo_s, ro_s}, 33'h0);
    model_reset();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cap_l.delete();
      step(1'b1, 16'(100 + k), 16'(-(100 + k)));
      repeat (6) step(1'b0, '0, '0);
      if (k < 5) check("refill_quiet", 33'(cap_l.size()), 33'h0);
    end
    check_cap("refill", 5, 101);

    repeat (400) step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));

    // Default geometry: quick fill, then widely spaced strobes each replaying 1021 samples.
    begin
      bit any_hi;
      any_hi = 1'b0;
      n_b = 0;
      for (int k = 0; k < BF - 1; k++) begin
        @(negedge clk);
        wr_b = 1'b1; l_b = 16'($urandom); r_b = 16'($urandom);
        bh_l[n_b] = l_b; bh_r[n_b] = r_b; n_b++;
        @(posedge clk); #1;
        if (seq_b) any_hi = 1'b1;
        wr_b = 1'b0;
      end
      check("big_fill_quiet", 33'(any_hi), 33'h0);
    end
    for (int p = 0; p < 20; p++) begin
      int len, first, errs;
      len = 0; first = -1; errs = 0;
      @(negedge clk);
      wr_b = 1'b1; l_b = 16'($urandom); r_b = 16'($urandom);
      bh_l[n_b] = l_b; bh_r[n_b] = r_b; n_b++;
      @(posedge clk); #1;
      wr_b = 1'b0;
      for (int c = 1; c <= 1100; c++) begin
        @(posedge clk); #1;
        if (seq_b) begin
          if (len == 0) first = c;
          if (len < BF && (lo_b !== bh_l[n_b - BF + len] || ro_b !== bh_r[n_b - BF + len]))
            errs++;
          len++;
        end
      end
      check("big_rise", 33'(first), 33'(1));
      check("big_len", 33'(len), 33'(BF));
      check("big_data_errs", 33'(errs), 33'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
